// File: rtl/multicycle_ctrl_pkg.sv
// Purpose : shared opcode constants, FSM state encoding, pc_sel/wb_sel encodings and legality check.
// Latency : n/a (declarations and a pure function only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    // Legal opcode/funct3 combinations; everything else traps.
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] func);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LOAD:   ok = (func == 3'd0) || (func == 3'd1) || (func == 3'd2) ||
                            (func == 3'd4) || (func == 3'd5);
            OP_STORE:  ok = (func <= 3'd2);
            OP_BRANCH: ok = (func != 3'd2) && (func != 3'd3);
            OP_JALR:   ok = (func == 3'd0);
            OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_perf_cnt.sv
// Purpose : cycle and retired-instruction counters (module ctrl_perf_cnt), both wrap mod 2^32.
// Latency : counts update on the clock edge after the counted cycle.
// Backpressure: none; counts every cycle presented.
// Ports: clk, rst (sync, active-high), pc_we (retire strobe) in; cycle_cnt, instret_cnt out.
module ctrl_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_we,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Counters read as zero while reset is held, not just after the reset edge.
    assign cycle_cnt   = rst ? '0 : cycle_q;
    assign instret_cnt = rst ? '0 : instret_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : multicycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP); optional perf counters under CTRL_PERF_CNT_EN.
// Latency : zero-wait branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.
// Backpressure: FETCH and MEM hold their request until the matching ack; acks without a request are ignored.
// Ports: clk, rst, op, func, br_taken, imem_ack, dmem_ack in; imem_req, dmem_req, dmem_we, ir_we, pc_we,
//        pc_sel, rf_we, wb_sel, alu_src, illegal, state out; cycle_cnt, instret_cnt out when CTRL_PERF_CNT_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic       illegal,
    output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t     state_q;
    logic [6:0] op_q;
    logic [2:0] func_q;
    logic       unused_func;

    // funct3 is latched for visibility alongside the opcode; no output depends on it after DECODE.
    assign unused_func = ^func_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            func_q  <= '0;
        end else begin
            case (state_q)
                ST_FETCH:  if (imem_ack) state_q <= ST_DECODE;
                ST_DECODE: begin
                    op_q    <= op;
                    func_q  <= func;
                    state_q <= is_legal(op, func) ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    if (op_q == OP_BRANCH)                          state_q <= ST_FETCH;
                    else if (op_q == OP_LOAD || op_q == OP_STORE)   state_q <= ST_MEM;
                    else                                            state_q <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack) state_q <= (op_q == OP_STORE) ? ST_FETCH : ST_WB;
                end
                ST_WB:     state_q <= ST_FETCH;
                ST_TRAP:   state_q <= ST_TRAP;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Outputs decode the current state and latched opcode; the ack/br_taken terms make the
    // completing cycle itself fire its strobe. Everything is forced low while rst is high so
    // an abandoned access never produces a write enable.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_PLUS4;
        rf_we    = 1'b0;
        wb_sel   = WB_SEL_ALU;
        alu_src  = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_EXEC: begin
                    alu_src = !(op_q == OP_OP || op_q == OP_BRANCH);
                    if (op_q == OP_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OP_STORE);
                    pc_we    = dmem_ack && (op_q == OP_STORE);
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (op_q)
                        OP_LOAD:         wb_sel = WB_SEL_MEM;
                        OP_JAL, OP_JALR: wb_sel = WB_SEL_PC4;
                        OP_LUI:          wb_sel = WB_SEL_IMM;
                        default:         wb_sel = WB_SEL_ALU;
                    endcase
                    if (op_q == OP_JAL)       pc_sel = PC_SEL_TARGET;
                    else if (op_q == OP_JALR) pc_sel = PC_SEL_JALR;
                end
                ST_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = rst ? 3'(ST_FETCH) : 3'(state_q);

`ifdef CTRL_PERF_CNT_EN
    ctrl_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .pc_we       (pc_we),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : directed, table-driven check of multicycle_ctrl plus hand sequences for trap/reset corners.
// Latency : n/a (testbench).
// Backpressure: n/a.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func;
    logic       br_taken;
    logic       imem_req, imem_ack;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       ir_we, pc_we, rf_we, alu_src, illegal;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .func     (func),
        .br_taken (br_taken),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .dmem_ack (dmem_ack),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .alu_src  (alu_src),
        .illegal  (illegal),
        .state    (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] func;
        logic       br;
        logic       iack;
        logic       dack;
    } in_t;

    // imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel, alu_src, illegal, state
    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic       illegal;
        logic [2:0] st;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t mk_in(logic r, logic [6:0] o, logic [2:0] f, logic b, logic ia, logic da);
        in_t x;
        x.rst = r; x.op = o; x.func = f; x.br = b; x.iack = ia; x.dack = da;
        return x;
    endfunction

    function automatic out_t mk_out(logic ireq, logic irw, logic dreq, logic dwe, logic pwe,
                                    logic [1:0] psel, logic rwe, logic [1:0] wsel,
                                    logic asrc, logic ill, logic [2:0] st);
        out_t y;
        y.imem_req = ireq; y.ir_we = irw; y.dmem_req = dreq; y.dmem_we = dwe; y.pc_we = pwe;
        y.pc_sel = psel; y.rf_we = rwe; y.wb_sel = wsel; y.alu_src = asrc; y.illegal = ill; y.st = st;
        return y;
    endfunction

    // Expected output shapes per state, written from the interface description.
    function automatic out_t e_rst();                 return mk_out(0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0); endfunction
    function automatic out_t e_fetch(logic ack);      return mk_out(1,ack,0,0,0,2'd0,0,2'd0,0,0,3'd0); endfunction
    function automatic out_t e_dec();                 return mk_out(0,0,0,0,0,2'd0,0,2'd0,0,0,3'd1); endfunction
    function automatic out_t e_exec(logic a, logic pwe, logic [1:0] ps);
                                                      return mk_out(0,0,0,0,pwe,ps,0,2'd0,a,0,3'd2); endfunction
    function automatic out_t e_mem(logic we, logic pwe);
                                                      return mk_out(0,0,1,we,pwe,2'd0,0,2'd0,0,0,3'd3); endfunction
    function automatic out_t e_wb(logic [1:0] ws, logic [1:0] ps);
                                                      return mk_out(0,0,0,0,1,ps,1,ws,0,0,3'd4); endfunction
    function automatic out_t e_trap();                return mk_out(0,0,0,0,0,2'd0,0,2'd0,0,1,3'd5); endfunction

    task automatic add(in_t x, out_t y);
        vec_t v;
        v.i = x; v.o = y;
        tbl.push_back(v);
    endtask

    function automatic out_t actual();
        return mk_out(imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
                      alu_src, illegal, state);
    endfunction

    task automatic drive(in_t x);
        rst = x.rst; op = x.op; func = x.func; br_taken = x.br; imem_ack = x.iack; dmem_ack = x.dack;
    endtask

    // One cycle: drive after the falling edge, compare 1 time unit later, before the rising edge.
    task automatic step(string name, in_t x, out_t y);
        out_t a;
        @(negedge clk);
        drive(x);
        #1;
        a = actual();
        n_chk++;
        if (a !== y) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (imem_req ir_we dmem_req dmem_we pc_we pc_sel rf_we wb_sel alu_src illegal state)",
                     name, a, y);
        end
    endtask

    task automatic chk1(string name, logic [31:0] got, logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, req);
        end
    endtask

    initial begin
        drive(mk_in(1, 7'h00, 3'd0, 0, 0, 0));

        // reset with a stray ack: imem_req stays low while rst is high
        add(mk_in(1, 7'h00, 3'd0, 0, 1, 0), e_rst());
        add(mk_in(1, 7'h00, 3'd0, 0, 1, 1), e_rst());
        // add, zero-wait: 4 cycles
        add(mk_in(0, 7'h33, 3'd0, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_exec(0, 0, 2'd0));
        add(mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_wb(2'd0, 2'd0));
        // lw, dmem_ack after 3 wait cycles: 8 cycles
        add(mk_in(0, 7'h03, 3'd2, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_mem(0, 0));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_mem(0, 0));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_mem(0, 0));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 1), e_mem(0, 0));
        add(mk_in(0, 7'h03, 3'd2, 0, 0, 0), e_wb(2'd1, 2'd0));
        // beq taken
        add(mk_in(0, 7'h63, 3'd0, 1, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h63, 3'd0, 1, 0, 0), e_dec());
        add(mk_in(0, 7'h63, 3'd0, 1, 0, 0), e_exec(0, 1, 2'd1));
        // bne not taken, imem waits one cycle
        add(mk_in(0, 7'h63, 3'd1, 0, 0, 0), e_fetch(0));
        add(mk_in(0, 7'h63, 3'd1, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h63, 3'd1, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h63, 3'd1, 0, 0, 0), e_exec(0, 1, 2'd0));
        // jal
        add(mk_in(0, 7'h6F, 3'd3, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h6F, 3'd3, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h6F, 3'd3, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h6F, 3'd3, 0, 0, 0), e_wb(2'd2, 2'd1));
        // jalr
        add(mk_in(0, 7'h67, 3'd0, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h67, 3'd0, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h67, 3'd0, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h67, 3'd0, 0, 0, 0), e_wb(2'd2, 2'd2));
        // lui
        add(mk_in(0, 7'h37, 3'd5, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h37, 3'd5, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h37, 3'd5, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h37, 3'd5, 0, 0, 0), e_wb(2'd3, 2'd0));
        // auipc, with a stray dmem_ack during FETCH that must be ignored
        add(mk_in(0, 7'h17, 3'd1, 0, 0, 1), e_fetch(0));
        add(mk_in(0, 7'h17, 3'd1, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h17, 3'd1, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h17, 3'd1, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h17, 3'd1, 0, 0, 0), e_wb(2'd0, 2'd0));
        // sw with one MEM wait
        add(mk_in(0, 7'h23, 3'd2, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h23, 3'd2, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h23, 3'd2, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h23, 3'd2, 0, 0, 0), e_mem(1, 0));
        add(mk_in(0, 7'h23, 3'd2, 0, 0, 1), e_mem(1, 1));
        // addi: returns to FETCH after the store
        add(mk_in(0, 7'h13, 3'd7, 0, 1, 0), e_fetch(1));
        add(mk_in(0, 7'h13, 3'd7, 0, 0, 0), e_dec());
        add(mk_in(0, 7'h13, 3'd7, 0, 0, 0), e_exec(1, 0, 2'd0));
        add(mk_in(0, 7'h13, 3'd7, 0, 0, 0), e_wb(2'd0, 2'd0));

        foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

        // Illegal opcode 0x0B: trap is sticky, no fetch request despite acks.
        step("ill0b_fetch", mk_in(0, 7'h0B, 3'd0, 0, 1, 0), e_fetch(1));
        step("ill0b_dec",   mk_in(0, 7'h0B, 3'd0, 0, 0, 0), e_dec());
        for (int c = 0; c < 4; c++)
            step($sformatf("ill0b_trap%0d", c), mk_in(0, 7'h33, 3'd0, 0, 1, c[0]), e_trap());
        step("ill0b_rst",   mk_in(1, 7'h00, 3'd0, 0, 1, 0), e_rst());
        // Branch with funct3=2 also traps; FETCH resumes after reset.
        step("illbr_fetch", mk_in(0, 7'h63, 3'd2, 0, 1, 0), e_fetch(1));
        step("illbr_dec",   mk_in(0, 7'h63, 3'd2, 0, 0, 0), e_dec());
        step("illbr_trap0", mk_in(0, 7'h63, 3'd2, 0, 1, 0), e_trap());
        step("illbr_trap1", mk_in(0, 7'h63, 3'd2, 0, 0, 1), e_trap());
        step("illbr_rst",   mk_in(1, 7'h00, 3'd0, 0, 0, 0), e_rst());
        step("illbr_resume", mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_fetch(0));

        // Store abandoned by reset mid-MEM: no pc_we, spurious dmem_ack in FETCH ignored.
        step("swrst_fetch", mk_in(0, 7'h23, 3'd0, 0, 1, 0), e_fetch(1));
        step("swrst_dec",   mk_in(0, 7'h23, 3'd0, 0, 0, 0), e_dec());
        step("swrst_exec",  mk_in(0, 7'h23, 3'd0, 0, 0, 0), e_exec(1, 0, 2'd0));
        step("swrst_mem",   mk_in(0, 7'h23, 3'd0, 0, 0, 0), e_mem(1, 0));
        step("swrst_rst",   mk_in(1, 7'h23, 3'd0, 0, 0, 1), e_rst());
        step("swrst_after", mk_in(0, 7'h23, 3'd0, 0, 0, 1), e_fetch(0));
        step("swrst_after2", mk_in(0, 7'h23, 3'd0, 0, 0, 1), e_fetch(0));

`ifdef CTRL_PERF_CNT_EN
        // Three zero-wait adds from reset: 12 cycles, 3 retired.
        step("perf_rst", mk_in(1, 7'h00, 3'd0, 0, 0, 0), e_rst());
        chk1("perf_cycle_rst", cycle_cnt, 32'd0);
        chk1("perf_instret_rst", instret_cnt, 32'd0);
        for (int n = 0; n < 3; n++) begin
            step("perf_f", mk_in(0, 7'h33, 3'd0, 0, 1, 0), e_fetch(1));
            step("perf_d", mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_dec());
            step("perf_e", mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_exec(0, 0, 2'd0));
            step("perf_w", mk_in(0, 7'h33, 3'd0, 0, 0, 0), e_wb(2'd0, 2'd0));
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk1("perf_cycle12", cycle_cnt, 32'd12);
        chk1("perf_instret3", instret_cnt, 32'd3);
        dut.u_perf.cycle_q = 32'hFFFF_FFFF;
        #1;
        chk1("perf_preset", cycle_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk1("perf_wrap", cycle_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule
